// File: rtl/rpn_eval_if.sv
// Character-stream bundle between the RPN evaluator and its neighbours:
// strobe/ack input characters and strobe/ack output characters.
interface rpn_eval_if;
  logic       IN_STB;
  logic [7:0] IN_CHAR;
  logic       IN_ACK;
  logic       OUT_STB;
  logic [7:0] OUT_CHAR;
  logic       OUT_ACK;

  modport master (output IN_STB, IN_CHAR, OUT_ACK, input IN_ACK, OUT_STB, OUT_CHAR);
  modport slave  (input IN_STB, IN_CHAR, OUT_ACK, output IN_ACK, OUT_STB, OUT_CHAR);
endinterface

// File: rtl/rpn_eval.sv
// Streaming postfix evaluator: signed operand stack, iterative divider, and
// decimal text output of the final result (or "E" after any error).
module rpn_eval #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input logic       CLK,
  input logic       RST,
  rpn_eval_if.slave bus
);
  // state | meaning
  // IDLE  | accept characters, push/apply operators
  // DIV   | 16-step restoring divide on magnitudes
  // CONV  | binary to decimal by repeated subtraction
  // SEND  | drain character buffer, then newline
  // ERR   | emit "E" and newline
  typedef enum logic [2:0] {IDLE, DIV, CONV, SEND, ERR} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  state_t                  state_q, state_d;
  logic                    in_ack_q, out_stb_q, err_q;
  logic [7:0]              out_char_q;
  logic [CW-1:0]           cnt_q;
  logic signed [WIDTH-1:0] stk [DEPTH];
  logic [WIDTH-1:0]        dq_q, dd_q, dr_q, mag_q;
  logic                    neg_q, started_q;
  logic [3:0]              div_cnt_q, digit_q;
  logic [2:0]              pow_idx_q, len_q, rd_q;
  logic [7:0]              cbuf [6];

  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  logic [7:0]              ch;
  logic                    accept, is_digit, is_eq, is_add, is_sub, is_mul, is_div, is_op;
  logic [AW-1:0]           idx_a, idx_b;
  logic signed [WIDTH-1:0] opa, opb, alu;
  logic                    push_err, op_err;

  assign ch       = bus.IN_CHAR;
  assign accept   = (state_q == IDLE) && bus.IN_STB && !in_ack_q;
  assign is_digit = (ch >= 8'h30) && (ch <= 8'h39);
  assign is_eq    = (ch == 8'h3D);
  assign is_add   = (ch == 8'h2B);
  assign is_sub   = (ch == 8'h2D);
  assign is_mul   = (ch == 8'h2A);
  assign is_div   = (ch == 8'h2F);
  assign is_op    = is_add || is_sub || is_mul || is_div;
  assign idx_a    = AW'(cnt_q - CW'(2));
  assign idx_b    = AW'(cnt_q - CW'(1));
  assign opa      = stk[idx_a];
  assign opb      = stk[idx_b];
  assign push_err = is_digit && (cnt_q == CW'(DEPTH));
  assign op_err   = is_op && ((cnt_q < CW'(2)) || (is_div && (opb == '0)));

  always_comb begin
    alu = opa + opb;
    if (is_sub)      alu = opa - opb;
    else if (is_mul) alu = opa * opb;
  end

  // Borrow of the trial subtraction doubles as the restore decision.
  logic [WIDTH:0]          r_sh, r_sub;
  logic                    div_ge;
  logic [WIDTH-1:0]        r_nx, q_nx;
  logic signed [WIDTH-1:0] div_res;
  assign r_sh    = {dr_q, dq_q[WIDTH-1]};
  assign r_sub   = r_sh - {1'b0, dd_q};
  assign div_ge  = !r_sub[WIDTH];
  assign r_nx    = div_ge ? r_sub[WIDTH-1:0] : r_sh[WIDTH-1:0];
  assign q_nx    = {dq_q[WIDTH-2:0], div_ge};
  assign div_res = neg_q ? -q_nx : q_nx;

  logic [WIDTH-1:0] pow;
  logic             pow_ge, conv_done;
  always_comb begin
    case (pow_idx_q)
      3'd0:    pow = WIDTH'(10000);
      3'd1:    pow = WIDTH'(1000);
      3'd2:    pow = WIDTH'(100);
      3'd3:    pow = WIDTH'(10);
      default: pow = WIDTH'(1);
    endcase
  end
  assign pow_ge    = (mag_q >= pow);
  assign conv_done = (pow_idx_q == 3'd4) && !pow_ge;

  logic [7:0] cur_char;
  logic       last_char;
  always_comb begin
    cur_char = 8'h0A;
    if (state_q == ERR) begin
      if (rd_q == 3'd0) cur_char = 8'h45;
    end else if (rd_q < len_q) begin
      cur_char = cbuf[rd_q];
    end
    last_char = (state_q == ERR) ? (rd_q == 3'd1) : (rd_q == len_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
        if (is_eq)                             state_d = (err_q || cnt_q != CW'(1)) ? ERR : CONV;
        else if (!err_q && is_div && !op_err)  state_d = DIV;
      end
      DIV:       if (div_cnt_q == 4'd0) state_d = IDLE;
      CONV:      if (conv_done) state_d = SEND;
      SEND, ERR: if (out_stb_q && bus.OUT_ACK && last_char) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  logic                    stk_we, buf_we;
  logic [AW-1:0]           stk_wa;
  logic signed [WIDTH-1:0] stk_wd;
  logic [2:0]              buf_wa;
  logic [7:0]              buf_wd;
  always_comb begin
    stk_we = 1'b0;
    stk_wa = idx_a;
    stk_wd = alu;
    buf_we = 1'b0;
    buf_wa = len_q;
    buf_wd = 8'h30 + {4'h0, digit_q};
    case (state_q)
      IDLE: if (accept && !err_q) begin
        if (is_digit && !push_err) begin
          stk_we = 1'b1;
          stk_wa = AW'(cnt_q);
          stk_wd = WIDTH'(ch[3:0]);
        end else if (is_op && !is_div && !op_err) begin
          stk_we = 1'b1;
        end else if (is_eq && cnt_q == CW'(1) && opb[WIDTH-1]) begin
          buf_we = 1'b1;
          buf_wa = 3'd0;
          buf_wd = 8'h2D;
        end
      end
      DIV: if (div_cnt_q == 4'd0) begin
        stk_we = 1'b1;
        stk_wd = div_res;
      end
      CONV: if (!pow_ge && (digit_q != 4'd0 || started_q || pow_idx_q == 3'd4)) buf_we = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (stk_we) stk[stk_wa] <= stk_wd;
    if (buf_we) cbuf[buf_wa] <= buf_wd;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      in_ack_q   <= 1'b0;
      out_stb_q  <= 1'b0;
      out_char_q <= 8'h00;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      dq_q       <= '0;
      dd_q       <= '0;
      dr_q       <= '0;
      neg_q      <= 1'b0;
      div_cnt_q  <= 4'd0;
      mag_q      <= '0;
      pow_idx_q  <= 3'd0;
      digit_q    <= 4'd0;
      started_q  <= 1'b0;
      len_q      <= 3'd0;
      rd_q       <= 3'd0;
    end else begin
      state_q  <= state_d;
      in_ack_q <= accept;
      case (state_q)
        IDLE: if (accept) begin
          if (is_eq) begin
            rd_q <= 3'd0;
            if (!err_q && cnt_q == CW'(1)) begin
              len_q     <= opb[WIDTH-1] ? 3'd1 : 3'd0;
              mag_q     <= mag_of(opb);
              pow_idx_q <= 3'd0;
              digit_q   <= 4'd0;
              started_q <= 1'b0;
            end
          end else if (!err_q) begin
            if (push_err || op_err) begin
              err_q <= 1'b1;
            end else if (is_digit) begin
              cnt_q <= cnt_q + CW'(1);
            end else if (is_div) begin
              dq_q      <= mag_of(opa);
              dd_q      <= mag_of(opb);
              dr_q      <= '0;
              neg_q     <= opa[WIDTH-1] ^ opb[WIDTH-1];
              div_cnt_q <= 4'd15;
            end else if (is_op) begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
        end
        DIV: begin
          dr_q <= r_nx;
          dq_q <= q_nx;
          if (div_cnt_q == 4'd0) cnt_q <= cnt_q - CW'(1);
          else                   div_cnt_q <= div_cnt_q - 4'd1;
        end
        CONV: begin
          if (pow_ge) begin
            mag_q   <= mag_q - pow;
            digit_q <= digit_q + 4'd1;
          end else begin
            if (buf_we) begin
              len_q     <= len_q + 3'd1;
              started_q <= 1'b1;
            end
            digit_q   <= 4'd0;
            pow_idx_q <= pow_idx_q + 3'd1;
          end
        end
        SEND, ERR: begin
          // One low cycle separates consecutive output characters.
          if (!out_stb_q) begin
            out_stb_q  <= 1'b1;
            out_char_q <= cur_char;
          end else if (bus.OUT_ACK) begin
            out_stb_q <= 1'b0;
            rd_q      <= rd_q + 3'd1;
            if (last_char) begin
              cnt_q <= '0;
              err_q <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.IN_ACK   = in_ack_q;
  assign bus.OUT_STB  = out_stb_q;
  assign bus.OUT_CHAR = out_char_q;
endmodule
